// File: rtl/servant_uart_pkg.sv
// Shared 8N1 UART definitions: receiver state encoding, frame constants and
// the clocks-per-bit divider calculation used by both RX and TX sides.
package servant_uart_pkg;

  localparam int unsigned DataBits  = 8;
  localparam int unsigned StopBits  = 1;
  localparam int unsigned FrameBits = 1 + DataBits + StopBits;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } rx_state_e;

  // Rounded integer division so the bit period error stays below half a clock.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/servant_uart_rx_fifo.sv
// Small synchronous FIFO for received bytes. The head entry is read straight
// from the storage registers, so it holds steady until it is popped.
module servant_uart_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PtrW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rptr_q];

  // A push into a full FIFO is still accepted when the head leaves this cycle.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/servant_uart_rx.sv
// 8N1 serial receiver: synchronises the line, samples each bit at its centre
// and queues completed bytes behind a valid/ready port.
module servant_uart_rx
  import servant_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 16000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int unsigned Div  = calc_div(CLK_FREQ_HZ, BAUD);
  localparam int unsigned CntW = $clog2(Div);
  localparam logic [CntW-1:0] CntFull = CntW'(Div - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(Div / 2 - 1);

  rx_state_e             state_q;
  logic                  rx_meta_q, rx_s_q;
  logic [CntW-1:0]       cnt_q;
  logic [2:0]            bit_idx_q;
  logic [DataBits-1:0]   shift_q;
  logic                  push_q, frame_err_q, overrun_q;
  logic                  tick, full, empty, pop;

  assign tick = (cnt_q == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= i_rx;
      rx_s_q      <= rx_meta_q;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      if (!tick) begin
        cnt_q <= cnt_q - 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (!rx_s_q) begin
            state_q <= StStart;
            cnt_q   <= CntHalf;
          end
        end
        StStart: begin
          if (tick) begin
            // A line back high at mid start bit was only a glitch.
            if (rx_s_q) begin
              state_q <= StIdle;
            end else begin
              state_q   <= StData;
              bit_idx_q <= '0;
              cnt_q     <= CntFull;
            end
          end
        end
        StData: begin
          if (tick) begin
            shift_q   <= {rx_s_q, shift_q[DataBits-1:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            cnt_q     <= CntFull;
            if (bit_idx_q == 3'd7) begin
              state_q <= StStop;
            end
          end
        end
        StStop: begin
          if (tick) begin
            if (rx_s_q) begin
              push_q  <= 1'b1;
              state_q <= StIdle;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= StBreak;
            end
          end
        end
        StBreak: begin
          if (rx_s_q) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pop = ~empty & i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= push_q & full & ~pop;
    end
  end

  servant_uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DataBits)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .push_i  (push_q),
    .wdata_i (shift_q),
    .pop_i   (pop),
    .rdata_o (o_data),
    .full_o  (full),
    .empty_o (empty)
  );

  assign o_valid     = ~empty;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_servant_uart_rx.sv
// Scoreboard bench for servant_uart_rx: bytes expected to arrive are queued
// as they are driven and compared when the receiver hands them out.
module tb_servant_uart_rx;

  localparam int Div = 139;  // round(16 MHz / 115200)

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;

  servant_uart_rx #(
    .CLK_FREQ_HZ (16000000),
    .BAUD        (115200),
    .FIFO_DEPTH  (4)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx        (rx),
    .o_data      (data),
    .o_valid     (valid),
    .i_ready     (ready),
    .o_frame_err (frame_err),
    .o_overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         fe_cnt  = 0;
  int         ov_cnt  = 0;
  int         t_vrise = -1;
  logic [7:0] exp_q[$];

  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic       prev_fe    = 1'b0;
  logic       prev_ov    = 1'b0;
  logic [7:0] prev_data  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    logic [7:0] e;
    if (frame_err) begin
      fe_cnt++;
      check("fe_ov_exclusive", {31'b0, overrun}, 0);
      check("fe_one_cycle", {31'b0, prev_fe}, 0);
    end
    if (overrun) begin
      ov_cnt++;
      check("ov_one_cycle", {31'b0, prev_ov}, 0);
    end
    if (valid && !prev_valid) t_vrise = cyc;
    if (prev_valid && !prev_ready && valid) check("hold_data", data, prev_data);
    if (valid && ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_byte", {31'b0, valid}, 0);
      end else begin
        e = exp_q.pop_front();
        check("rx_data", data, e);
      end
    end
    prev_valid = valid;
    prev_ready = ready;
    prev_fe    = frame_err;
    prev_ov    = overrun;
    prev_data  = data;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; optionally raises ready as the stop bit starts.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic expect_it,
                           input logic ready_at_stop);
    if (expect_it) exp_q.push_back(b);
    rx = 1'b0;
    step(Div);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(Div);
    end
    if (ready_at_stop) ready = 1'b1;
    rx = stop_bit;
    step(Div);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      step(1);
    end
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    int fe0, ov0, t_fall, lat;
    rst_n = 1'b0;
    rx    = 1'b1;
    ready = 1'b1;

    // Line activity during reset must not produce anything.
    for (int i = 0; i < 16; i++) begin
      rx = 1'($urandom_range(0, 1));
      step(7);
      check("reset_outputs", {21'b0, valid, frame_err, overrun, data}, 0);
    end
    rx = 1'b1;
    step(5);
    rst_n = 1'b1;
    step(3 * Div);
    check("idle_after_reset", {31'b0, valid}, 0);
    check("idle_no_pulses", fe_cnt + ov_cnt, 0);

    // Single byte with latency window: 9.5 bit times + 2 sync + 1 visibility, +/-2.
    t_vrise = -1;
    t_fall  = cyc;
    send_byte(8'h48, 1'b1, 1'b1, 1'b0);
    wait_drain("drain_single", 200);
    lat = t_vrise - t_fall;
    check("latency_window", {31'b0, (lat >= 1322 && lat <= 1325)}, 1);

    // Glitch shorter than half a bit is ignored.
    rx = 1'b0;
    step(Div / 4);
    rx = 1'b1;
    step(2 * Div);
    check("glitch_no_fe", fe_cnt, 0);
    check("glitch_no_valid", {31'b0, valid}, 0);
    send_byte(8'h55, 1'b1, 1'b1, 1'b0);
    wait_drain("drain_after_glitch", 200);

    // Framing error: stop low, line low for 3 bit times.
    fe0 = fe_cnt;
    send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
    step(2 * Div);
    rx = 1'b1;
    step(2 * Div);
    check("frame_err_once", fe_cnt - fe0, 1);
    check("frame_no_data", {31'b0, valid}, 0);
    send_byte(8'h3C, 1'b1, 1'b1, 1'b0);
    wait_drain("drain_after_break", 200);

    // Overrun: fifth byte dropped while the consumer stalls.
    ov0   = ov_cnt;
    ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      send_byte(8'(k), 1'b1, k < 5, 1'b0);
      if (k == 4) check("no_overrun_until_full", ov_cnt - ov0, 0);
    end
    check("overrun_on_byte5", ov_cnt - ov0, 1);
    check("full_valid", {31'b0, valid}, 1);
    step(10);
    ready = 1'b1;
    wait_drain("drain_overrun", 200);
    step(5);
    check("empty_after_drain", {31'b0, valid}, 0);

    // Same again but the consumer wakes during byte 5's stop bit.
    ov0   = ov_cnt;
    ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      send_byte(8'(k), 1'b1, 1'b1, k == 5);
    end
    wait_drain("drain_pop_while_full", 200);
    check("no_overrun_with_pop", ov_cnt - ov0, 0);

    // Reset during data bit 3 of 0xFF.
    fe0   = fe_cnt;
    ov0   = ov_cnt;
    ready = 1'b1;
    rx    = 1'b0;
    step(Div);
    for (int i = 0; i < 3; i++) begin
      rx = 1'b1;
      step(Div);
    end
    step(Div / 2);
    rst_n = 1'b0;
    step(2);
    check("midframe_reset_outputs", {21'b0, valid, frame_err, overrun, data}, 0);
    step(Div);
    rst_n = 1'b1;
    step(3 * Div);
    check("midframe_no_valid", {31'b0, valid}, 0);
    check("midframe_no_pulses", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    send_byte(8'h7E, 1'b1, 1'b1, 1'b0);
    wait_drain("drain_after_reset", 200);

    step(20);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
